// File: rtl/boot_pkg.sv
// Shared types and frame constants for the serial program loader.
package boot_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_H,
        S_LEN_L,
        S_D_HI,
        S_D_LO,
        S_WR,
        S_CSUM,
        S_DONE,
        S_ERR
    } boot_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         LEN_W        = 16;
    localparam int         CSUM_W       = 8;

    // States in which the host must keep bytes flowing.
    function automatic logic is_timed(input boot_state_t s);
        return (s == S_LEN_H) || (s == S_LEN_L) || (s == S_D_HI) ||
               (s == S_D_LO)  || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte watchdog: reloads to TIMEOUT on clear, counts down while enabled.
module boot_timeout #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= CW'(TIMEOUT);
        end else if (i_clear) begin
            r_cnt <= CW'(TIMEOUT);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Frames a host byte stream (SYNC, LEN, words, CSUM) into instruction-memory
// debug writes, holding the CPU off fetch until a frame checks out.
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int          DEPTH     = 16384,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [7:0]  SYNC      = SYNC_DEFAULT,
    parameter int          TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_debug,
    output logic [15:0] im_in_addr,
    output logic [15:0] im_wr_instr,
    output logic        cpu_hold,
    output logic        boot_done,
    output logic        boot_err
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

    boot_state_t         r_state;
    logic [7:0]          r_len_hi;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [7:0]          r_d_hi;
    logic [CSUM_W-1:0]   r_csum;
    logic                r_rx_ready;
    logic                r_im_debug;
    logic [15:0]         r_im_in_addr;
    logic [15:0]         r_im_wr_instr;
    logic                r_cpu_hold;
    logic                r_boot_done;
    logic                r_boot_err;

    logic                w_fire;
    logic                w_timed;
    logic                w_expire;
    logic                w_timeout;
    logic [LEN_W-1:0]    w_len_cat;
    logic [LEN_W-1:0]    w_idx_next;
    logic [CSUM_W-1:0]   w_csum_add;

    assign w_fire     = rx_valid && r_rx_ready;
    assign w_timed    = is_timed(r_state);
    assign w_timeout  = w_timed && !w_fire && w_expire;
    assign w_len_cat  = {r_len_hi, rx_data};
    assign w_idx_next = r_idx + 16'd1;
    assign w_csum_add = r_csum + rx_data;

    boot_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_fire || !w_timed),
        .i_en     (w_timed),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_len_hi      <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_d_hi        <= '0;
            r_csum        <= '0;
            r_rx_ready    <= 1'b1;
            r_im_debug    <= 1'b0;
            r_im_in_addr  <= '0;
            r_im_wr_instr <= '0;
            r_cpu_hold    <= 1'b1;
            r_boot_done   <= 1'b0;
            r_boot_err    <= 1'b0;
        end else begin
            r_im_debug <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_fire && (rx_data == SYNC)) begin
                        r_state     <= S_LEN_H;
                        r_csum      <= '0;
                        r_idx       <= '0;
                        r_boot_done <= 1'b0;
                        r_boot_err  <= 1'b0;
                        r_cpu_hold  <= 1'b1;
                    end
                end
                S_LEN_H: begin
                    if (w_fire) begin
                        r_len_hi <= rx_data;
                        r_csum   <= w_csum_add;
                        r_state  <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (w_fire) begin
                        r_len  <= w_len_cat;
                        r_csum <= w_csum_add;
                        if ({1'b0, w_len_cat} > DEPTH_L) begin
                            r_state    <= S_ERR;
                            r_boot_err <= 1'b1;
                        end else if (w_len_cat == '0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_D_HI;
                        end
                    end
                end
                S_D_HI: begin
                    if (w_fire) begin
                        r_d_hi  <= rx_data;
                        r_csum  <= w_csum_add;
                        r_state <= S_D_LO;
                    end
                end
                S_D_LO: begin
                    // Stage the write so it is presented during the WR cycle.
                    if (w_fire) begin
                        r_csum        <= w_csum_add;
                        r_im_debug    <= 1'b1;
                        r_im_in_addr  <= BASE_ADDR + r_idx;
                        r_im_wr_instr <= {r_d_hi, rx_data};
                        r_rx_ready    <= 1'b0;
                        r_state       <= S_WR;
                    end
                end
                S_WR: begin
                    r_rx_ready <= 1'b1;
                    r_idx      <= w_idx_next;
                    r_state    <= (w_idx_next == r_len) ? S_CSUM : S_D_HI;
                end
                S_CSUM: begin
                    if (w_fire) begin
                        if (rx_data == r_csum) begin
                            r_state     <= S_DONE;
                            r_boot_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                        end else begin
                            r_state    <= S_ERR;
                            r_boot_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b1;
                end
            endcase

            if (w_timeout) begin
                r_state    <= S_ERR;
                r_boot_err <= 1'b1;
            end
        end
    end

    assign rx_ready    = r_rx_ready;
    assign im_debug    = r_im_debug;
    assign im_in_addr  = r_im_in_addr;
    assign im_wr_instr = r_im_wr_instr;
    assign cpu_hold    = r_cpu_hold;
    assign boot_done   = r_boot_done;
    assign boot_err    = r_boot_err;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: frames, checksum errors, length limits,
// inactivity timeout, back-to-back flow control and mid-frame reset.
module tb_boot_loader_ctrl;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_debug;
    logic [15:0] im_in_addr;
    logic [15:0] im_wr_instr;
    logic        cpu_hold;
    logic        boot_done;
    logic        boot_err;

    int n_cmp = 0;
    int n_bad = 0;

    int          cyc = 0;
    int          wr_cnt = 0;
    int          bad_ready = 0;
    int          bad_pulse = 0;
    logic        prev_dbg = 1'b0;
    logic [15:0] wr_addr [16];
    logic [15:0] wr_data [16];

    always #5 clk = ~clk;

    boot_loader_ctrl #(
        .DEPTH     (16384),
        .BASE_ADDR (16'h0000),
        .SYNC      (8'hA5),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .im_debug    (im_debug),
        .im_in_addr  (im_in_addr),
        .im_wr_instr (im_wr_instr),
        .cpu_hold    (cpu_hold),
        .boot_done   (boot_done),
        .boot_err    (boot_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Write log plus flow-control invariants: rx_ready low exactly when a write is presented.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (im_debug === 1'b1) begin
                if (wr_cnt < 16) begin
                    wr_addr[wr_cnt] <= im_in_addr;
                    wr_data[wr_cnt] <= im_wr_instr;
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (rx_ready === im_debug) bad_ready <= bad_ready + 1;
            if (im_debug === 1'b1 && prev_dbg) bad_pulse <= bad_pulse + 1;
            prev_dbg <= im_debug;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("send_wait", 32'(guard), 32'd0);
        @(negedge clk);
    endtask

    logic [7:0] f_good [10] = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC2};

    initial begin
        int t0;
        int guard;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_rx_ready", rx_ready, 1);
        check("rst_im_debug", im_debug, 0);
        check("rst_addr", im_in_addr, 0);
        check("rst_data", im_wr_instr, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", boot_done, 0);
        check("rst_err", boot_err, 0);

        // Good frame, rx_valid held high throughout. 00+03+12+34+AB+CD+00+01 = 0x1C2 -> 0xC2.
        t0 = cyc;
        for (int i = 0; i < 10; i++) send(f_good[i]);
        rx_valid = 1'b0;
        check("good_cycles", 32'(cyc - t0), 32'd13);
        check("good_done", boot_done, 1);
        check("good_err", boot_err, 0);
        check("good_hold", cpu_hold, 0);
        @(negedge clk);
        check("good_wr_cnt", 32'(wr_cnt), 32'd3);
        check("good_a0", wr_addr[0], 16'h0000);
        check("good_d0", wr_data[0], 16'h1234);
        check("good_a1", wr_addr[1], 16'h0001);
        check("good_d1", wr_data[1], 16'hABCD);
        check("good_a2", wr_addr[2], 16'h0002);
        check("good_d2", wr_data[2], 16'h0001);

        // Same payload, checksum off by one: writes still happen, error flagged.
        send(8'hA5);
        check("rearm_done", boot_done, 0);
        check("rearm_hold", cpu_hold, 1);
        for (int i = 1; i < 9; i++) send(f_good[i]);
        send(8'hC3);
        rx_valid = 1'b0;
        check("bad_err", boot_err, 1);
        check("bad_done", boot_done, 0);
        check("bad_hold", cpu_hold, 1);
        @(negedge clk);
        check("bad_wr_cnt", 32'(wr_cnt), 32'd6);
        check("bad_a3", wr_addr[3], 16'h0000);
        check("bad_d5", wr_data[5], 16'h0001);

        // Zero-length frame.
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        rx_valid = 1'b0;
        check("zero_done", boot_done, 1);
        check("zero_err", boot_err, 0);
        @(negedge clk);
        check("zero_wr_cnt", 32'(wr_cnt), 32'd6);

        // Length one past DEPTH (0x4001) errors straight after LEN_LO.
        send(8'hA5); send(8'h40); send(8'h01);
        rx_valid = 1'b0;
        check("len_err", boot_err, 1);
        check("len_done", boot_done, 0);
        check("len_ready", rx_ready, 1);
        @(negedge clk);
        check("len_wr_cnt", 32'(wr_cnt), 32'd6);

        // Stall after the first data byte.
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
        rx_valid = 1'b0;
        repeat (TO / 2) @(negedge clk);
        check("to_early", boot_err, 0);
        guard = 0;
        while (boot_err !== 1'b1 && guard < TO + 10) begin
            @(negedge clk);
            guard++;
        end
        check("to_err", boot_err, 1);
        check("to_hold", cpu_hold, 1);
        check("to_wr_cnt", 32'(wr_cnt), 32'd6);

        // Re-arm and load one word (01+56+78 = 0xCF); must restart at address 0.
        send(8'hA5);
        check("to_rearm_err", boot_err, 0);
        send(8'h00); send(8'h01); send(8'h56); send(8'h78); send(8'hCF);
        rx_valid = 1'b0;
        check("reload_done", boot_done, 1);
        @(negedge clk);
        check("reload_wr_cnt", 32'(wr_cnt), 32'd7);
        check("reload_a", wr_addr[6], 16'h0000);
        check("reload_d", wr_data[6], 16'h5678);

        // Reset while waiting for the low data byte, with that byte on the bus.
        send(8'hA5); send(8'h00); send(8'h01); send(8'hAB);
        rst_n    = 1'b0;
        rx_data  = 8'hCD;
        rx_valid = 1'b1;
        @(negedge clk);
        check("mid_rx_ready", rx_ready, 1);
        check("mid_im_debug", im_debug, 0);
        check("mid_addr", im_in_addr, 0);
        check("mid_data", im_wr_instr, 0);
        check("mid_hold", cpu_hold, 1);
        check("mid_done", boot_done, 0);
        check("mid_err", boot_err, 0);
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_wr_cnt", 32'(wr_cnt), 32'd7);

        check("ready_vs_wr", 32'(bad_ready), 32'd0);
        check("single_pulse", 32'(bad_pulse), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
